// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory slave for the memory-access stage.
// Accepts one load/store request at a time on a valid/ready request channel and
// answers on a valid/ready response channel after a fixed, parameterised latency.
// All memory effects (write or read capture) happen at the request-accept edge.

module data_mem_responder #(
    parameter int Width   = 32,
    parameter int Depth   = 64,
    parameter int Latency = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [Width-1:0]   req_addr,
    input  logic [Width-1:0]   req_wdata,
    input  logic [Width/8-1:0] req_be,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [Width-1:0]   rsp_rdata,
    output logic               rsp_err
);

    localparam int NumBytes = Width / 8;
    localparam int IdxBits  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [Width-3:0] DepthLimit = (Width-2)'(Depth);
    localparam logic [3:0] WaitStart = 4'(Latency - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]       counter;
    logic [3:0]       counter_next;

    logic [Width-1:0] mem [Depth];

    logic [Width-1:0] rdata_q;
    logic             err_q;

    logic             accept;
    logic             addr_err;
    logic [Width-3:0] word_index;
    logic [IdxBits-1:0] mem_idx;

    // Decode the byte address into a word index and flag misaligned or out-of-range accesses.
    always_comb begin
        word_index = req_addr[Width-1:2];
        mem_idx    = word_index[IdxBits-1:0];
        addr_err   = (req_addr[1:0] != 2'b00) || (word_index >= DepthLimit);
    end

    // A request is taken only when the responder is idle and the requester offers one.
    assign accept = req_valid && req_ready;

    // State and latency counter registers; reset returns to IDLE and drops any pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            counter <= 4'd0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    // Next-state, counter and handshake outputs for the single-transaction sequencer.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (Latency == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next   = WAIT;
                        counter_next = WaitStart;
                    end
                end
            end
            WAIT: begin
                counter_next = counter - 4'd1;
                if (counter == 4'd1) begin
                    state_next   = RESP;
                    counter_next = 4'd0;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                counter_next = 4'd0;
            end
        endcase
    end

    // Memory array: cleared on reset, byte-enabled store on a legal accepted write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (accept && req_write && !addr_err) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (req_be[b]) begin
                    mem[mem_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Capture the response payload at the accept edge so it stays stable until the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            err_q <= addr_err;
            if (addr_err || req_write) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= mem[mem_idx];
            end
        end
    end

    // Response payload is forced to zero whenever no response is being presented.
    always_comb begin
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        if (rsp_valid) begin
            rsp_rdata = rdata_q;
            rsp_err   = err_q;
        end
    end

endmodule
